inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 255, max cycles mem_req may wait for mem_ack before error (range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports pc_in  in  16  current PC from pc_unit; pc_op  out  2  PC command (NOP=0, INC=1, ASSIGN=2, RESET=3); pc_target  out  16  ASSIGN value.
REQ-005 SHALL have ports mem_req  out  1; mem_addr  out  16; mem_ack  in  1  read complete, mem_data valid this cycle; mem_data  in  16.
REQ-006 SHALL have ports redirect_valid  in  1  branch/jump taken; redirect_pc  in  16  new PC.
REQ-007 SHALL have ports instr_valid  out  1; instr_ready  in  1; instr  out  16; instr_pc  out  16  address instr was fetched from.
REQ-008 SHALL have port fetch_err  out  1  sticky memory-timeout flag.

Function
REQ-009 SHALL implement states PCRST, FETCH, DRAIN, HALT.
REQ-010 PCRST: pc_op=RESET for exactly one cycle, then FETCH.
REQ-011 FETCH with buffer space: mem_req=1, mem_addr=pc_in, pc_op=NOP until mem_ack; no space: mem_req=0.
REQ-012 On mem_ack in FETCH (no redirect): push {mem_data, pc_in} into buffer, pc_op=INC same cycle; instr_valid=1 from next cycle (1-cycle latency).
REQ-013 Buffer pop on instr_valid && instr_ready; instr/instr_pc SHALL stay stable while instr_valid && !instr_ready.
REQ-014 Space test SHALL count a same-cycle pop as free space (no bubble at full throughput).
REQ-015 redirect_valid (any state except PCRST/HALT): pc_op=ASSIGN, pc_target=redirect_pc, buffer flushed, instr_valid=0 next cycle.
REQ-016 Redirect has priority over INC: redirect coinciding with mem_ack discards that data; next state FETCH.
REQ-017 Redirect in FETCH with mem_req=1 and no mem_ack: go DRAIN.
REQ-018 DRAIN: mem_req=1, mem_addr held at latched pre-redirect address; on mem_ack data discarded, go FETCH; a further redirect re-ASSIGNs and stays DRAIN.
REQ-019 Wait counter (8 bits) SHALL count cycles with mem_req=1 && !mem_ack, clear on mem_ack or redirect; reaching WAIT_MAX: fetch_err=1, go HALT.
REQ-020 HALT: mem_req=0, pc_op=NOP, buffer contents still drainable, redirects ignored, exit only by reset.
REQ-021 pc_op SHALL be NOP whenever no rule above applies.

Reset
REQ-022 rst_n=0 at a clock edge SHALL enter PCRST, flush buffer, clear wait counter and fetch_err, abandon any outstanding request.
REQ-023 During and out of reset: mem_req=0, instr_valid=0, fetch_err=0, pc_op=NOP while rst_n=0, instr/instr_pc/pc_target/mem_addr=0.

Configuration
REQ-024 Macro FETCH_PREFETCH_EN defined: buffer depth 2 (FIFO order), fetching continues while decode stalls with one entry held.
REQ-025 FETCH_PREFETCH_EN undefined: buffer depth 1; mem_req=0 while the entry is held and not popped that cycle.

Verification
REQ-026 Reset release, mem_ack 1 cycle after each req, instr_ready=1 -> pc_op=RESET once, then mem_addr 0,1,2,3 with instr_pc matching, one instr per cycle.
REQ-027 instr_ready=0 for 5 cycles after first instr -> instr/instr_pc frozen; with macro exactly 2 entries buffered, without exactly 1, no extra mem_req issued.
REQ-028 redirect_valid with redirect_pc=16'h0040 coincident with mem_ack -> pc_op=ASSIGN, data dropped, next mem_addr=16'h0040, no instr from old stream.
REQ-029 Redirect at 16'h0080 while waiting on ack for addr 5 -> DRAIN holds mem_addr=5 until ack, ack data discarded, next fetch at 16'h0080.
REQ-030 WAIT_MAX=4, mem_ack held low -> fetch_err=1 after 4 waiting cycles, mem_req=0, sticky until rst_n=0; rst_n=0 mid-wait clears all.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch: drives the PC unit, reads from memory and queues instructions for decode.
// Define FETCH_PREFETCH_EN for a 2-entry prefetch buffer; the default build uses a 1-entry buffer.
module inst_fetch #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  output logic [1:0]  pc_op,
  output logic [15:0] pc_target,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        fetch_err
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam logic [7:0]  WAIT_LAST = 8'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    ST_PCRST = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_NOP    = 2'd0,
    PC_INC    = 2'd1,
    PC_ASSIGN = 2'd2,
    PC_RESET  = 2'd3
  } pc_op_e;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] pc;
  } entry_t;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  entry_t          buf_q [DEPTH];
  entry_t          buf_d [DEPTH];
  logic [7:0]      wait_q, wait_d;
  logic [15:0]     drain_addr_q, drain_addr_d;
  logic            err_q, err_d;

  pc_op_e          op_c;
  logic            req_c;
  logic [15:0]     addr_c;
  logic            push, flush, pop, space;
  logic [CW-1:0]   wr_idx;

  // A same-cycle pop frees a slot, so a full buffer still fetches at full rate.
  assign pop    = (cnt_q != '0) && instr_ready;
  assign space  = (cnt_q != CW'(DEPTH)) || pop;
  assign wr_idx = cnt_q - CW'(pop);

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    op_c         = PC_NOP;
    req_c        = 1'b0;
    addr_c       = '0;
    push         = 1'b0;
    flush        = 1'b0;
    wait_d       = wait_q;
    drain_addr_d = drain_addr_q;
    err_d        = err_q;

    unique case (state_q)
      ST_PCRST: begin
        op_c    = PC_RESET;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        req_c = space;
        if (space) addr_c = pc_in;
        if (redirect_valid) begin
          op_c   = PC_ASSIGN;
          flush  = 1'b1;
          wait_d = '0;
          if (space && !mem_ack) begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_in;
          end
        end else if (space && mem_ack) begin
          push   = 1'b1;
          op_c   = PC_INC;
          wait_d = '0;
        end else if (space) begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        // The pre-redirect read is still in flight; finish it and throw the data away.
        req_c  = 1'b1;
        addr_c = drain_addr_q;
        if (redirect_valid) begin
          op_c  = PC_ASSIGN;
          flush = 1'b1;
        end
        if (mem_ack) begin
          state_d = ST_FETCH;
          wait_d  = '0;
        end else if (redirect_valid) begin
          wait_d = '0;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: state_d = ST_PCRST;
    endcase
  end

  // Shift-register FIFO: entry 0 is always the head presented to decode.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) buf_d[i] = buf_q[i+1];
      end
      if (push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (CW'(i) == wr_idx) buf_d[i] = '{data: mem_data, pc: pc_in};
        end
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_PCRST;
      cnt_q        <= '0;
      wait_q       <= '0;
      err_q        <= 1'b0;
      drain_addr_q <= '0;
      // NOTE: the buffer is only a couple of flops and its head is visible on instr/instr_pc, so it is reset too.
      for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      drain_addr_q <= drain_addr_d;
      buf_q        <= buf_d;
    end
  end

  // Outputs are forced quiet while rst_n is low, before the reset edge has been seen.
  assign pc_op       = rst_n ? op_c : PC_NOP;
  assign pc_target   = (rst_n && op_c == PC_ASSIGN) ? redirect_pc : '0;
  assign mem_req     = rst_n & req_c;
  assign mem_addr    = rst_n ? addr_c : '0;
  assign instr_valid = rst_n & (cnt_q != '0);
  assign instr       = rst_n ? buf_q[0].data : '0;
  assign instr_pc    = rst_n ? buf_q[0].pc : '0;
  assign fetch_err   = rst_n & err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: models the PC unit and a memory whose ack can be held off.
// Memory returns addr ^ KEY so every instruction word is traceable to its fetch address.
module tb_inst_fetch;

  localparam logic [15:0] KEY = 16'hC3C3;
`ifdef FETCH_PREFETCH_EN
  localparam int EXP_DEPTH = 2;
`else
  localparam int EXP_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_in;
  logic [1:0]  pc_op;
  logic [15:0] pc_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        fetch_err;

  logic        ack_en;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acks;

  inst_fetch #(.WAIT_MAX(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_in          (pc_in),
    .pc_op          (pc_op),
    .pc_target      (pc_target),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, then let everything settle before checks.
  task automatic step(input logic rdy, input logic redir, input logic [15:0] rpc);
    @(negedge clk);
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_pc_op", pc_op, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_err", fetch_err, 0);
    @(negedge clk);
    #2;
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pc_target", pc_target, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("pcrst_op", pc_op, 3);
    check("pcrst_req", mem_req, 0);
  endtask

  // PC unit and memory model.
  initial begin
    logic [1:0]  op_s;
    logic [15:0] tgt_s;
    mem_ack  = 1'b0;
    mem_data = '0;
    pc_in    = 16'h1234;
    forever begin
      @(negedge clk);
      #1;
      mem_ack  = mem_req && ack_en;
      mem_data = mem_ack ? (mem_addr ^ KEY) : 16'hDEAD;
      #2;
      op_s  = pc_op;
      tgt_s = pc_target;
      @(posedge clk);
      #1;
      case (op_s)
        2'd1:    pc_in = pc_in + 16'd1;
        2'd2:    pc_in = tgt_s;
        2'd3:    pc_in = '0;
        default: ;
      endcase
    end
  end

  initial begin
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ack_en         = 1'b1;

    // Streaming at full rate after reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0);
      check("seq_req", mem_req, 1);
      check("seq_addr", mem_addr, i);
      check("seq_op", pc_op, 1);
      if (i > 0) begin
        check("seq_valid", instr_valid, 1);
        check("seq_instr_pc", instr_pc, i - 1);
        check("seq_instr", instr, 16'(i - 1) ^ KEY);
      end else begin
        check("seq_first_valid", instr_valid, 0);
      end
    end

    // Decode stall: head frozen, buffer fills to its depth and fetching stops.
    do_reset();
    step(1'b0, 1'b0, '0);
    check("stall_first_addr", mem_addr, 0);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0);
      check("stall_valid", instr_valid, 1);
      check("stall_instr_pc", instr_pc, 0);
      check("stall_instr", instr, KEY);
      if (mem_req && mem_ack) acks++;
    end
    check("stall_extra_fetch", acks, EXP_DEPTH - 1);
    check("stall_no_req", mem_req, 0);
    check("stall_pc", pc_in, EXP_DEPTH);
    step(1'b1, 1'b0, '0);
    check("resume_instr_pc", instr_pc, 0);
    check("resume_req", mem_req, 1);
    check("resume_addr", mem_addr, EXP_DEPTH);
    step(1'b1, 1'b0, '0);
    check("resume_next_pc", instr_pc, 1);
    check("resume_next_instr", instr, 16'h0001 ^ KEY);

    // Redirect coinciding with an ack: data dropped, stream restarts at the target.
    step(1'b1, 1'b1, 16'h0040);
    check("redir_ack_req", mem_req, 1);
    check("redir_op", pc_op, 2);
    check("redir_target", pc_target, 16'h0040);
    step(1'b1, 1'b0, '0);
    check("redir_flush_valid", instr_valid, 0);
    check("redir_new_addr", mem_addr, 16'h0040);
    check("redir_new_op", pc_op, 1);
    step(1'b1, 1'b0, '0);
    check("redir_new_valid", instr_valid, 1);
    check("redir_new_pc", instr_pc, 16'h0040);
    check("redir_new_instr", instr, 16'h0040 ^ KEY);

    // Redirect while a read is outstanding: drain it at the old address.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
    ack_en = 1'b0;
    step(1'b1, 1'b0, '0);
    check("drain_wait_addr", mem_addr, 5);
    check("drain_wait_pc", instr_pc, 4);
    step(1'b1, 1'b1, 16'h0080);
    check("drain_redir_op", pc_op, 2);
    check("drain_redir_addr", mem_addr, 5);
    step(1'b1, 1'b0, '0);
    check("drain_req", mem_req, 1);
    check("drain_addr_a", mem_addr, 5);
    check("drain_op", pc_op, 0);
    check("drain_valid", instr_valid, 0);
    step(1'b1, 1'b0, '0);
    check("drain_addr_b", mem_addr, 5);
    ack_en = 1'b1;
    step(1'b1, 1'b0, '0);
    check("drain_ack_addr", mem_addr, 5);
    check("drain_ack_op", pc_op, 0);
    step(1'b1, 1'b0, '0);
    check("drain_refetch_addr", mem_addr, 16'h0080);
    check("drain_refetch_valid", instr_valid, 0);
    check("drain_refetch_op", pc_op, 1);
    step(1'b1, 1'b0, '0);
    check("drain_new_pc", instr_pc, 16'h0080);
    check("drain_new_instr", instr, 16'h0080 ^ KEY);

    // Memory timeout: error after WAIT_MAX waiting cycles, sticky, redirects ignored.
    do_reset();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0);
      check("to_wait_req", mem_req, 1);
      check("to_wait_err", fetch_err, 0);
    end
    step(1'b1, 1'b0, '0);
    check("to_err", fetch_err, 1);
    check("to_halt_req", mem_req, 0);
    step(1'b1, 1'b1, 16'h0100);
    check("halt_redir_op", pc_op, 0);
    check("halt_redir_target", pc_target, 0);
    check("halt_err_sticky", fetch_err, 1);
    ack_en = 1'b1;
    step(1'b1, 1'b0, '0);
    check("halt_req", mem_req, 0);
    check("halt_err_hold", fetch_err, 1);

    // Reset mid-wait clears the wait counter: a full WAIT_MAX is needed again.
    do_reset();
    ack_en = 1'b0;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0);
      check("rewait_req", mem_req, 1);
      check("rewait_err", fetch_err, 0);
    end
    step(1'b1, 1'b0, '0);
    check("rewait_timeout", fetch_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
